// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: mode constants, output state encoding and a width-generic immediate-extension function
package imm_ext_pkg;

    localparam logic [1:0] IMM_SIGN   = 2'd0;
    localparam logic [1:0] IMM_ZERO   = 2'd1;
    localparam logic [1:0] IMM_UPPER  = 2'd2;
    localparam logic [1:0] IMM_BRANCH = 2'd3;

    localparam int MAX_W = 64;

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

    // Widths arrive as arguments so one function serves every instance; callers truncate to OUT_W
    function automatic logic [MAX_W-1:0] imm_extend(
        input logic [MAX_W-1:0] d,
        input logic [1:0]       mode,
        input int               in_w,
        input int               out_w,
        input int               br_shift
    );
        logic [MAX_W-1:0] zx, sx, r;
        zx = d & ~({MAX_W{1'b1}} << in_w);
        sx = $signed(zx << (MAX_W - in_w)) >>> (MAX_W - in_w);
        r  = mode == IMM_ZERO   ? zx :
             mode == IMM_UPPER  ? zx << (out_w - in_w) :
             mode == IMM_BRANCH ? sx << br_shift : sx;
        return r & ~({MAX_W{1'b1}} << out_w);
    endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: input and output valid/ready channels of the immediate-extension stage
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [IN_W-1:0]  in_imm_i;
    logic [1:0]       in_mode_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [OUT_W-1:0] out_data_o;
    logic             out_neg_o;

    modport master (
        output in_valid_i, in_imm_i, in_mode_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_neg_o
    );

    modport slave (
        input  in_valid_i, in_imm_i, in_mode_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_neg_o
    );
endinterface

// File: rtl/imm_ext_skid.sv
// imm_ext_skid: generic one-entry skid buffer; upstream ready is a flop (skid empty)
module imm_ext_skid #(
    parameter int W = 33
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [W-1:0] s_data_i,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [W-1:0] m_data_o
);
    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    // Park a beat when downstream stalls; drain it on the next downstream accept
    always_comb begin
        full_d = full_q ? !m_ready_i : s_valid_i && !m_ready_i;
        data_d = full_q ? data_q : s_data_i;
    end

    // Skid storage; reset discards a parked beat
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign s_ready_o = !full_q;
    assign m_valid_o = full_q || s_valid_i;
    assign m_data_o  = full_q ? data_q : s_data_i;
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered MIPS immediate extension with valid/ready; IMM_EXT_SKID_EN adds a skid buffer
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    imm_extend_pipe_if.slave bus
);
    out_state_e     state_q, state_d;
    logic [OUT_W:0] data_q, data_d;
    logic [OUT_W-1:0] ext_data;
    logic [OUT_W:0] ext, src_data;
    logic           src_valid, sink_ready, load;

    assign ext_data   = OUT_W'(imm_extend(MAX_W'(bus.in_imm_i), bus.in_mode_i, IN_W, OUT_W, BR_SHIFT));
    assign ext        = {ext_data[OUT_W-1], ext_data};
    assign sink_ready = state_q == OUT_EMPTY || bus.out_ready_i;
    assign load       = src_valid && sink_ready;

`ifdef IMM_EXT_SKID_EN
    imm_ext_skid #(.W(OUT_W + 1)) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .s_valid_i (bus.in_valid_i),
        .s_ready_o (bus.in_ready_o),
        .s_data_i  (ext),
        .m_valid_o (src_valid),
        .m_ready_i (sink_ready),
        .m_data_o  (src_data)
    );
`else
    assign src_valid      = bus.in_valid_i;
    assign src_data       = ext;
    assign bus.in_ready_o = sink_ready;
`endif

    // Output register: load on accept, empty on consume without a refill, otherwise hold
    always_comb begin
        state_d = load ? OUT_FULL : bus.out_ready_i ? OUT_EMPTY : state_q;
        data_d  = load ? src_data : data_q;
    end

    // Result and sign bit are captured together so out_neg_o is a flop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= OUT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign bus.out_valid_o = state_q == OUT_FULL;
    assign bus.out_data_o  = data_q[OUT_W-1:0];
    assign bus.out_neg_o   = data_q[OUT_W];
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: scoreboard bench for imm_extend_pipe (IN_W=16, OUT_W=32, BR_SHIFT=2)
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();
    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    int consumed = 0;
    logic [32:0] exp_q[$];
    logic [32:0] held;
    logic [32:0] e;
    logic        stall_prev = 1'b0;

    function automatic logic [32:0] model(input logic [15:0] d, input logic [1:0] m);
        logic [31:0] s, r;
        s = {{16{d[15]}}, d};
        case (m)
            2'd0:    r = s;
            2'd1:    r = {16'h0000, d};
            2'd2:    r = {d, 16'h0000};
            default: r = {s[29:0], 2'b00};
        endcase
        return {r[31], r};
    endfunction

    // Scoreboard and stall-stability monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!bus.out_valid_o || {bus.out_neg_o, bus.out_data_o} !== held) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%b neg/data=%h, expected valid=1 neg/data=%h", bus.out_valid_o, {bus.out_neg_o, bus.out_data_o}, held);
                end
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                checks++;
                consumed++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_extra: unexpected result neg/data=%h, expected none", {bus.out_neg_o, bus.out_data_o});
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_neg_o, bus.out_data_o} !== e) begin
                        failures++;
                        $display("FAIL sb_data: got neg/data=%h expected %h", {bus.out_neg_o, bus.out_data_o}, e);
                    end
                end
            end
            stall_prev = bus.out_valid_o && !bus.out_ready_i;
            held = {bus.out_neg_o, bus.out_data_o};
        end
    end

    task automatic send(input logic [15:0] d, input logic [1:0] m);
        bus.in_valid_i = 1'b1;
        bus.in_imm_i   = d;
        bus.in_mode_i  = m;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                exp_q.push_back(model(d, m));
                @(posedge clk);
                #1;
                bus.in_valid_i = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready_o=%b after 50 cycles, expected 1", bus.in_ready_o);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.in_imm_i    = '0;
        bus.in_mode_i   = '0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid_o); end
        checks++;
        if (bus.out_data_o !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 00000000", bus.out_data_o); end
        checks++;
        if (bus.out_neg_o !== 1'b0) begin failures++; $display("FAIL reset_neg: got %b expected 0", bus.out_neg_o); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready_o); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_modes;
        logic [15:0] imms [5] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h7FFF};
        logic [1:0]  mds  [5] = '{IMM_SIGN, IMM_ZERO, IMM_UPPER, IMM_BRANCH, IMM_BRANCH};
        logic [31:0] exps [5] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h0001FFFC};
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(imms[i], mds[i]);
            @(negedge clk);
            checks++;
            if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL mode%0d_latency: out_valid_o=%b expected 1", i, bus.out_valid_o); end
            checks++;
            if (bus.out_data_o !== exps[i]) begin failures++; $display("FAIL mode%0d_data: got %h expected %h", i, bus.out_data_o, exps[i]); end
            checks++;
            if (bus.out_neg_o !== exps[i][31]) begin failures++; $display("FAIL mode%0d_neg: got %b expected %b", i, bus.out_neg_o, exps[i][31]); end
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL mode%0d_drain: out_valid_o=%b expected 0", i, bus.out_valid_o); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure;
        int c0;
        c0 = consumed;
        bus.out_ready_i = 1'b0;
        send(16'h0001, IMM_SIGN);
        fork
            send(16'h0002, IMM_SIGN);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (!bus.out_valid_o || bus.out_data_o !== 32'h00000001) begin
                        failures++;
                        $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=00000001", bus.out_valid_o, bus.out_data_o);
                    end
                end
                @(posedge clk);
                #1;
                bus.out_ready_i = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (consumed - c0 !== 2) begin failures++; $display("FAIL bp_count: got %0d results expected 2", consumed - c0); end
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("FAIL bp_lost: %0d results outstanding expected 0", exp_q.size()); end
        checks++;
        if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL bp_dup: out_valid_o=%b expected 0", bus.out_valid_o); end
    endtask

    task automatic test_back_to_back;
        int  c0;
        logic seen;
        c0 = consumed;
        seen = 1'b0;
        bus.out_ready_i = 1'b1;
        fork
            for (int i = 0; i < 8; i++) send(16'(16'h1000 * i + 16'h00F3 * i), 2'(i));
            begin
                for (int i = 0; i < 10 && !seen; i++) begin
                    @(negedge clk);
                    seen = bus.out_valid_o;
                end
                checks++;
                if (!seen) begin failures++; $display("FAIL b2b_start: out_valid_o=0 expected 1 within 10 cycles"); end
                for (int i = 1; i < 8; i++) begin
                    @(negedge clk);
                    checks++;
                    if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_gap: beat %0d out_valid_o=%b expected 1", i, bus.out_valid_o); end
                end
            end
        join
        @(negedge clk);
        checks++;
        if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_tail: out_valid_o=%b expected 0", bus.out_valid_o); end
        checks++;
        if (consumed - c0 !== 8) begin failures++; $display("FAIL b2b_count: got %0d results expected 8", consumed - c0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        int   c0;
        logic done;
        c0 = consumed;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(16'($urandom), 2'($urandom));
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            for (int i = 0; i < 400 && !done; i++) begin
                @(posedge clk);
                #1;
                bus.out_ready_i = $urandom_range(0, 2) != 0;
            end
        join
        bus.out_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (consumed - c0 !== 40) begin failures++; $display("FAIL rand_count: got %0d results expected 40", consumed - c0); end
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("FAIL rand_lost: %0d results outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_stall;
        bus.out_ready_i = 1'b0;
        send(16'h8000, IMM_SIGN);
        bus.in_valid_i = 1'b1;
        bus.in_imm_i   = 16'hAAAA;
        bus.in_mode_i  = IMM_SIGN;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_stall_valid: got %b expected 0", bus.out_valid_o); end
        checks++;
        if (bus.out_data_o !== 32'h0) begin failures++; $display("FAIL rst_stall_data: got %h expected 00000000", bus.out_data_o); end
        checks++;
        if (bus.out_neg_o !== 1'b0) begin failures++; $display("FAIL rst_stall_neg: got %b expected 0", bus.out_neg_o); end
        exp_q.delete();
        bus.in_valid_i = 1'b0;
        #7;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_stall_ready: got %b expected 1", bus.in_ready_o); end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_stale: out_valid_o=%b data=%h expected valid 0", bus.out_valid_o, bus.out_data_o); end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset;
        test_modes;
        test_backpressure;
        test_back_to_back;
        test_random;
        test_reset_mid_stall;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
